// File: rtl/spi_integ_trig_ctrl.sv
// Integration-window sequencer with average-magnitude fault detection and
// trigger lockout gating, all in the SPI clock domain.
module spi_integ_trig_ctrl #(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 48
) (
  input  logic                       spi_clk,
  input  logic                       reset,
  input  logic                       spi_en,
  input  logic                       integ_en,
  input  logic [31:0]                integ_window,
  input  logic [14:0]                integ_thresh_avg,
  input  logic [31:0]                trig_lockout,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       trig_in,
  output logic                       trig_out,
  output logic                       trig_dropped,
  output logic                       integ_active,
  output logic                       window_done,
  output logic                       over_thresh
);

  // Handshake: sample_valid is a single-cycle strobe with no backpressure;
  // every cycle it is high in RUN consumes exactly one sample.

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_e;

  localparam logic [SAMPLE_W-1:0] ONE_S = {{(SAMPLE_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  limit_q, limit_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       win_q, win_d;
  logic [31:0]       lock_cnt_q, lock_cnt_d;
  logic              trig_out_q, trig_out_d;
  logic              trig_dropped_q, trig_dropped_d;
  logic              window_done_q, window_done_d;
  logic              over_thresh_q, over_thresh_d;

  logic [SAMPLE_W-1:0] mag;
  logic [ACC_W-1:0]    acc_next;
  logic [31:0]         cnt_next;
  logic [ACC_W-1:0]    limit_new;

  // Two's-complement negation in SAMPLE_W bits maps the most negative value
  // onto 2^(SAMPLE_W-1) when read unsigned, so no saturation is needed.
  assign mag       = sample[SAMPLE_W-1] ? (~$unsigned(sample) + ONE_S) : $unsigned(sample);
  assign acc_next  = acc_q + ACC_W'(mag);
  assign cnt_next  = cnt_q + 32'd1;
  assign limit_new = ACC_W'(integ_thresh_avg) * ACC_W'(integ_window);

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    win_d         = win_q;
    limit_d       = limit_q;
    window_done_d = 1'b0;
    over_thresh_d = over_thresh_q;
    case (state_q)
      ST_IDLE: begin
        over_thresh_d = 1'b0;
        if (spi_en && integ_en && integ_window != 32'd0) begin
          state_d = ST_RUN;
          win_d   = integ_window;
          limit_d = limit_new;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (!spi_en || !integ_en) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (sample_valid) begin
          if (cnt_next == win_q) begin
            // Window boundary: restart immediately with freshly latched config.
            window_done_d = 1'b1;
            acc_d         = '0;
            cnt_d         = '0;
            win_d         = integ_window;
            limit_d       = limit_new;
            if (acc_next > limit_q) begin
              over_thresh_d = 1'b1;
              state_d       = ST_FAULT;
            end else if (integ_window == 32'd0) begin
              state_d = ST_IDLE;
            end
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_next;
          end
        end
      end
      ST_FAULT: begin
        if (!spi_en) begin
          state_d       = ST_IDLE;
          over_thresh_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lock_cnt_d     = lock_cnt_q;
    trig_out_d     = 1'b0;
    trig_dropped_d = 1'b0;
    if (!spi_en) begin
      lock_cnt_d = '0;
    end else if (trig_in && lock_cnt_q == 32'd0) begin
      trig_out_d = 1'b1;
      lock_cnt_d = trig_lockout;
    end else if (lock_cnt_q != 32'd0) begin
      lock_cnt_d     = lock_cnt_q - 32'd1;
      trig_dropped_d = trig_in;
    end
  end

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      limit_q        <= '0;
      cnt_q          <= '0;
      win_q          <= '0;
      lock_cnt_q     <= '0;
      trig_out_q     <= 1'b0;
      trig_dropped_q <= 1'b0;
      window_done_q  <= 1'b0;
      over_thresh_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      limit_q        <= limit_d;
      cnt_q          <= cnt_d;
      win_q          <= win_d;
      lock_cnt_q     <= lock_cnt_d;
      trig_out_q     <= trig_out_d;
      trig_dropped_q <= trig_dropped_d;
      window_done_q  <= window_done_d;
      over_thresh_q  <= over_thresh_d;
    end
  end

  assign trig_out     = trig_out_q;
  assign trig_dropped = trig_dropped_q;
  assign integ_active = (state_q == ST_RUN);
  assign window_done  = window_done_q;
  assign over_thresh  = over_thresh_q;

endmodule

// File: tb/tb_spi_integ_trig_ctrl.sv
// Directed bench for spi_integ_trig_ctrl; outputs are compared as the packed
// vector {trig_out, trig_dropped, integ_active, window_done, over_thresh}.
module tb_spi_integ_trig_ctrl;

  logic               spi_clk = 1'b0;
  logic               reset = 1'b1;
  logic               spi_en = 1'b0;
  logic               integ_en = 1'b0;
  logic [31:0]        integ_window = '0;
  logic [14:0]        integ_thresh_avg = '0;
  logic [31:0]        trig_lockout = '0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample = '0;
  logic               trig_in = 1'b0;
  logic               trig_out, trig_dropped, integ_active, window_done, over_thresh;
  logic [4:0]         outs;

  int n_vec = 0;
  int n_err = 0;

  spi_integ_trig_ctrl #(.SAMPLE_W(16), .ACC_W(48)) dut (
    .spi_clk          (spi_clk),
    .reset            (reset),
    .spi_en           (spi_en),
    .integ_en         (integ_en),
    .integ_window     (integ_window),
    .integ_thresh_avg (integ_thresh_avg),
    .trig_lockout     (trig_lockout),
    .sample_valid     (sample_valid),
    .sample           (sample),
    .trig_in          (trig_in),
    .trig_out         (trig_out),
    .trig_dropped     (trig_dropped),
    .integ_active     (integ_active),
    .window_done      (window_done),
    .over_thresh      (over_thresh)
  );

  assign outs = {trig_out, trig_dropped, integ_active, window_done, over_thresh};

  always #5 spi_clk = ~spi_clk;

  task automatic tick();
    @(posedge spi_clk);
    #1;
  endtask

  task automatic go_idle();
    spi_en = 1'b0; integ_en = 1'b0; sample_valid = 1'b0; trig_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_vec++;
    if (outs !== 5'b00000) begin $display("FAIL reset_idle: got %b want 00000", outs); n_err++; end
    reset = 1'b0; spi_en = 1'b1; integ_en = 1'b1;
    integ_window = 32'd100; integ_thresh_avg = 15'd10; trig_lockout = 32'd6; trig_in = 1'b1;
    tick();
    n_vec++;
    if (outs !== 5'b10100) begin $display("FAIL reset_first_run: got %b want 10100", outs); n_err++; end
    trig_in = 1'b0; sample_valid = 1'b1; sample = 16'sd1000;
    tick();
    n_vec++;
    if (outs !== 5'b00100) begin $display("FAIL reset_accum: got %b want 00100", outs); n_err++; end
    reset = 1'b1;
    #1;
    n_vec++;
    if (outs !== 5'b00000) begin $display("FAIL reset_async: got %b want 00000", outs); n_err++; end
    integ_window = 32'd1; integ_thresh_avg = 15'd5; sample = 16'sd5; trig_in = 1'b1;
    tick();
    n_vec++;
    if (outs !== 5'b00000) begin $display("FAIL reset_held: got %b want 00000", outs); n_err++; end
    reset = 1'b0;
    tick();
    n_vec++;
    if (outs !== 5'b10100) begin $display("FAIL reset_release: got %b want 10100", outs); n_err++; end
    trig_in = 1'b0;
    tick();
    n_vec++;
    if (outs !== 5'b00110) begin $display("FAIL reset_clean_acc: got %b want 00110", outs); n_err++; end
    go_idle();
    n_vec++;
    if (outs !== 5'b00000) begin $display("FAIL reset_to_idle: got %b want 00000", outs); n_err++; end
  endtask

  task automatic test_window();
    logic signed [15:0] smp [10];
    logic [4:0]         ex  [10];
    smp = '{16'sd100, -16'sd100, 16'sd100, 16'sd100, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1};
    ex  = '{5'b00100, 5'b00100, 5'b00100, 5'b00110, 5'b00100,
            5'b00100, 5'b00100, 5'b00110, 5'b00100, 5'b00110};
    go_idle();
    integ_window = 32'd4; integ_thresh_avg = 15'd100; spi_en = 1'b1; integ_en = 1'b1;
    tick();
    n_vec++;
    if (outs !== 5'b00100) begin $display("FAIL win_start: got %b want 00100", outs); n_err++; end
    for (int i = 0; i < 10; i++) begin
      // Shrinking the window mid-way must only apply from the next boundary.
      if (i == 5) integ_window = 32'd2;
      sample_valid = 1'b1; sample = smp[i];
      tick();
      n_vec++;
      if (outs !== ex[i]) begin $display("FAIL win_sample_%0d: got %b want %b", i, outs, ex[i]); n_err++; end
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_fault();
    logic signed [15:0] smp [4];
    smp = '{16'sd100, -16'sd101, 16'sd100, 16'sd100};
    go_idle();
    integ_window = 32'd4; integ_thresh_avg = 15'd100; spi_en = 1'b1; integ_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; sample = smp[i];
      tick();
      n_vec++;
      if (i < 3 && outs !== 5'b00100) begin $display("FAIL fault_acc_%0d: got %b want 00100", i, outs); n_err++; end
      if (i == 3 && outs !== 5'b00011) begin $display("FAIL fault_hit: got %b want 00011", outs); n_err++; end
    end
    sample = 16'sd100;
    tick();
    n_vec++;
    if (outs !== 5'b00001) begin $display("FAIL fault_ignore: got %b want 00001", outs); n_err++; end
    integ_en = 1'b0;
    tick();
    n_vec++;
    if (outs !== 5'b00001) begin $display("FAIL fault_integ_low: got %b want 00001", outs); n_err++; end
    integ_en = 1'b1;
    tick();
    n_vec++;
    if (outs !== 5'b00001) begin $display("FAIL fault_integ_high: got %b want 00001", outs); n_err++; end
    spi_en = 1'b0; sample_valid = 1'b0;
    tick();
    n_vec++;
    if (outs !== 5'b00000) begin $display("FAIL fault_clear: got %b want 00000", outs); n_err++; end
  endtask

  task automatic test_full_scale();
    go_idle();
    integ_window = 32'd1; integ_thresh_avg = 15'd32767; spi_en = 1'b1; integ_en = 1'b1;
    tick();
    sample_valid = 1'b1; sample = 16'sd32767;
    tick();
    n_vec++;
    if (outs !== 5'b00110) begin $display("FAIL fs_pos_max: got %b want 00110", outs); n_err++; end
    sample = -16'sd32768;
    tick();
    n_vec++;
    if (outs !== 5'b00011) begin $display("FAIL fs_neg_min: got %b want 00011", outs); n_err++; end
    go_idle();
  endtask

  task automatic test_trig_lockout();
    logic [4:0] e;
    go_idle();
    spi_en = 1'b1; trig_lockout = 32'd3; trig_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = ((k - 1) % 4 == 0) ? 5'b10000 : 5'b01000;
      n_vec++;
      if (outs !== e) begin $display("FAIL trig_lock3_%0d: got %b want %b", k, outs, e); n_err++; end
    end
    trig_in = 1'b0;
    tick();
    tick();
    n_vec++;
    if (outs !== 5'b00000) begin $display("FAIL trig_quiet: got %b want 00000", outs); n_err++; end
    trig_lockout = 32'd0; trig_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_vec++;
      if (outs !== 5'b10000) begin $display("FAIL trig_lock0_%0d: got %b want 10000", k, outs); n_err++; end
    end
    spi_en = 1'b0;
    tick();
    n_vec++;
    if (outs !== 5'b00000) begin $display("FAIL trig_spi_off: got %b want 00000", outs); n_err++; end
    trig_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    go_idle();
    integ_window = 32'd2; integ_thresh_avg = 15'd100; spi_en = 1'b1; integ_en = 1'b1;
    tick();
    sample_valid = 1'b1; sample = 16'sd10;
    tick();
    integ_en = 1'b0;
    tick();
    n_vec++;
    if (outs !== 5'b00000) begin $display("FAIL abort_last: got %b want 00000", outs); n_err++; end
    sample_valid = 1'b0; integ_window = 32'd0; integ_en = 1'b1;
    tick();
    tick();
    n_vec++;
    if (outs !== 5'b00000) begin $display("FAIL zero_window: got %b want 00000", outs); n_err++; end
    integ_window = 32'd2;
    tick();
    n_vec++;
    if (outs !== 5'b00100) begin $display("FAIL restart_run: got %b want 00100", outs); n_err++; end
    sample_valid = 1'b1;
    tick();
    n_vec++;
    if (outs !== 5'b00100) begin $display("FAIL restart_s1: got %b want 00100", outs); n_err++; end
    tick();
    n_vec++;
    if (outs !== 5'b00110) begin $display("FAIL restart_s2: got %b want 00110", outs); n_err++; end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_window();
    test_fault();
    test_full_scale();
    test_trig_lockout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_integ_trig_ctrl.md
Name: spi_integ_trig_ctrl

Overview:
Runs in the SPI clock domain, downstream of the synchronized configuration registers. It sequences back-to-back integration windows over the DAC/ADC sample stream and accumulates sample magnitudes per window. It flags a sticky over-threshold fault when a window's average magnitude exceeds the configured limit. It also gates external triggers with a programmable lockout.

Parameters:
SAMPLE_W, 16, signed sample width (two's complement)
ACC_W, 48, accumulator and limit width; must hold (2^(SAMPLE_W-1))*(2^32-1)

Ports:
spi_clk  input  1  SPI-domain clock
reset  input  1  asynchronous, active-high reset
spi_en  input  1  stable SPI enable; low forces idle and clears fault
integ_en  input  1  stable integrator enable
integ_window  input  32  window length in samples; 0 disables integration
integ_thresh_avg  input  15  average-magnitude threshold
trig_lockout  input  32  cycles of trigger dead time after an accepted trigger
sample_valid  input  1  sample strobe
sample  input  SAMPLE_W  signed sample
trig_in  input  1  raw trigger request, level sampled every cycle
trig_out  output  1  one-cycle accepted-trigger pulse
trig_dropped  output  1  one-cycle pulse: trig_in seen during lockout
integ_active  output  1  high while in RUN
window_done  output  1  one-cycle pulse per completed window
over_thresh  output  1  sticky fault

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, accumulator/count/limit/lockout counter 0.
- States: IDLE, RUN, FAULT.
- IDLE -> RUN when spi_en && integ_en && integ_window != 0.
  - On that edge: latch win = integ_window and limit = integ_thresh_avg * integ_window (unsigned, ACC_W bits); clear acc and cnt.
  - integ_active rises the cycle after the condition.
- RUN, on sample_valid:
  - mag = |sample| zero-extended; |-2^(SAMPLE_W-1)| = 2^(SAMPLE_W-1), no saturation.
  - acc_next = acc + mag; cnt_next = cnt + 1.
- RUN, last sample (cnt_next == win):
  - Compare acc_next > limit (strict).
  - Next cycle, window_done = 1, and over_thresh = 1 if the compare was true.
  - Same edge: acc and cnt cleared; win and limit re-latched from current inputs; if integ_window is now 0, go to IDLE instead.
  - No dead cycle: a sample on the cycle after the last sample is counted as sample 1 of the next window.
  - If the compare was true, go to FAULT instead.
- Config changes mid-window are ignored until the next window boundary.
- RUN -> IDLE the cycle after spi_en == 0 or integ_en == 0.
  - Partial window discarded, no window_done.
  - Abort has priority over a same-cycle last sample.
- FAULT:
  - integ_active = 0, samples ignored, over_thresh held.
  - Exit only on spi_en == 0 (-> IDLE, over_thresh cleared next cycle) or reset.
  - integ_en low does not clear the fault.
- Trigger lockout (independent of the integrator state machine):
  - Accept when spi_en && trig_in && lock_cnt == 0.
  - On accept: trig_out = 1 the next cycle; lock_cnt loaded with trig_lockout.
  - Otherwise, if lock_cnt != 0, lock_cnt decrements.
  - After a trigger accepted at cycle t, trig_in is ignored on cycles t+1..t+N (N = trig_lockout); next possible accept is t+N+1.
  - N = 0: a trigger can be accepted every cycle.
  - trig_in while lock_cnt != 0: trig_dropped pulses the next cycle.
  - spi_en == 0: lock_cnt cleared, no trig_out, no trig_dropped.
  - trig_lockout changes take effect only at the next accept.
- Latencies:
  - trig_in -> trig_out: 1 cycle.
  - Last sample_valid -> window_done/over_thresh: 1 cycle.

Test Plan:
- Reset mid-RUN (acc nonzero, lock_cnt = 5): all outputs 0 immediately; after release with enables high, integ_active rises 1 cycle later and the first window starts from acc = 0.
- integ_window = 4, thresh = 100, samples 100, -100, 100, 100 on consecutive cycles -> window_done 1 cycle after the 4th, over_thresh stays 0 (400 not > 400); the next window starts with no gap.
- Same setup, samples 100, -101, 100, 100 -> over_thresh and window_done 1 cycle after the last sample, state FAULT, integ_active 0; integ_en toggled low/high -> fault held; spi_en low 1 cycle -> over_thresh 0.
- Sample -32768, window = 1, thresh = 32767 -> magnitude counted as 32768, over_thresh = 1.
- trig_lockout = 3, trig_in held high 10 cycles -> trig_out at cycles 1, 5, 9; trig_dropped on the other cycles after the first; trig_lockout = 0 -> trig_out every cycle.
- integ_en dropped on the same cycle as the last sample of a window -> no window_done, IDLE next cycle; integ_window = 0 with enables high -> stays IDLE, integ_active 0.
